// File: rtl/lieat_exu_mdu_pkg.sv
// Shared definitions for the LIEAT multiply/divide unit: FSM states,
// op one-hot bit positions and the default datapath width.
package lieat_exu_mdu_pkg;

    localparam int unsigned MDU_XLEN_DEF = 32;

    localparam int unsigned OP_MUL    = 0;
    localparam int unsigned OP_MULH   = 1;
    localparam int unsigned OP_MULHSU = 2;
    localparam int unsigned OP_MULHU  = 3;
    localparam int unsigned OP_DIV    = 4;
    localparam int unsigned OP_DIVU   = 5;
    localparam int unsigned OP_REM    = 6;
    localparam int unsigned OP_REMU   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lieat_exu_mdu_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for restoring the sign of the final product/quotient/remainder.
module lieat_mdu_signfix
    import lieat_exu_mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN_DEF
) (
    input  logic [XLEN-1:0] din,
    input  logic            neg,
    output logic [XLEN-1:0] dout
);

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    assign dout = neg ? ((~din) + ONE) : din;

endmodule

// File: rtl/lieat_exu_mdu.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and, when
// LIEAT_MDU_DIV_EN is defined, radix-2 restoring divide (otherwise div ops are illegal).
module lieat_exu_mdu
    import lieat_exu_mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mdu_req_valid,
    output logic            mdu_req_ready,
    input  logic [XLEN-1:0] mdu_req_op1,
    input  logic [XLEN-1:0] mdu_req_op2,
    input  logic [7:0]      mdu_req_op,
    input  logic            mdu_flush,
    output logic            mdu_rsp_valid,
    input  logic            mdu_rsp_ready,
    output logic [XLEN-1:0] mdu_rsp_res
);

    localparam int unsigned     CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_nxt;
    logic [XLEN-1:0]   b_q;
    logic              hi_q, rneg_q;
    logic [XLEN-1:0]   res_q;

    logic              accept, legal, fast;
    logic [XLEN-1:0]   fast_res;
    logic              sign_a, sign_b, a_neg, b_neg, rneg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] fin_raw, fin_fix;
    logic [XLEN-1:0]   fin_res;

`ifdef LIEAT_MDU_DIV_EN
    logic              op_div_any, is_rem_op;
    logic              div_q, rem_q;
    logic [XLEN:0]     div_trial;
`endif

    assign mdu_req_ready = (state_q == ST_IDLE) && !mdu_flush;
    assign accept        = mdu_req_valid && mdu_req_ready;
    assign mdu_rsp_valid = (state_q == ST_DONE);
    assign mdu_rsp_res   = res_q;

    // ---------------- request decode ----------------
`ifdef LIEAT_MDU_DIV_EN
    assign legal      = $onehot(mdu_req_op);
    assign op_div_any = |mdu_req_op[OP_REMU:OP_DIV];
    assign is_rem_op  = mdu_req_op[OP_REM] || mdu_req_op[OP_REMU];
`else
    assign legal      = $onehot(mdu_req_op) && (mdu_req_op[OP_REMU:OP_DIV] == 4'b0000);
`endif

    assign sign_a = mdu_req_op[OP_MULH] || mdu_req_op[OP_MULHSU] ||
                    mdu_req_op[OP_DIV]  || mdu_req_op[OP_REM];
    assign sign_b = mdu_req_op[OP_MULH] || mdu_req_op[OP_DIV] || mdu_req_op[OP_REM];
    assign a_neg  = sign_a && mdu_req_op1[XLEN-1];
    assign b_neg  = sign_b && mdu_req_op2[XLEN-1];

`ifdef LIEAT_MDU_DIV_EN
    assign rneg = is_rem_op ? a_neg : (a_neg ^ b_neg);
`else
    assign rneg = a_neg ^ b_neg;
`endif

    lieat_mdu_signfix #(.XLEN(XLEN)) u_fix_a (
        .din  (mdu_req_op1),
        .neg  (a_neg),
        .dout (mag_a)
    );

    lieat_mdu_signfix #(.XLEN(XLEN)) u_fix_b (
        .din  (mdu_req_op2),
        .neg  (b_neg),
        .dout (mag_b)
    );

    always_comb begin
        fast     = !legal;
        fast_res = '0;
`ifdef LIEAT_MDU_DIV_EN
        if (legal && op_div_any && (mdu_req_op2 == '0)) begin
            fast     = 1'b1;
            fast_res = is_rem_op ? mdu_req_op1 : '1;
        end else if (legal && (mdu_req_op[OP_DIV] || mdu_req_op[OP_REM]) &&
                     (mdu_req_op1 == XMIN) && (mdu_req_op2 == '1)) begin
            fast     = 1'b1;
            fast_res = is_rem_op ? '0 : XMIN;
        end
`endif
    end

    // ---------------- iteration step ----------------
    // acc holds {partial product | remainder, multiplier | quotient} and
    // shifts one bit per cycle in opposite directions for mul and div.
    assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

`ifdef LIEAT_MDU_DIV_EN
    assign div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};

    always_comb begin
        acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
        if (div_q) begin
            if (div_trial[XLEN])
                acc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
            else
                acc_nxt = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
    end

    assign fin_raw = rem_q ? {{XLEN{1'b0}}, acc_nxt[2*XLEN-1:XLEN]} : acc_nxt;
`else
    assign acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    assign fin_raw = acc_nxt;
`endif

    // Negating the full double-width value keeps mulh/mulhsu high halves correct.
    lieat_mdu_signfix #(.XLEN(2*XLEN)) u_fix_res (
        .din  (fin_raw),
        .neg  (rneg_q),
        .dout (fin_fix)
    );

    assign fin_res = hi_q ? fin_fix[2*XLEN-1:XLEN] : fin_fix[XLEN-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mdu_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) state_d = fast ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == CNT_ONE) state_d = ST_DONE;
                ST_DONE: if (mdu_rsp_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            hi_q   <= 1'b0;
            rneg_q <= 1'b0;
            res_q  <= '0;
`ifdef LIEAT_MDU_DIV_EN
            div_q  <= 1'b0;
            rem_q  <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q  <= CNT_INIT;
            acc_q  <= {{XLEN{1'b0}}, mag_a};
            b_q    <= mag_b;
            hi_q   <= mdu_req_op[OP_MULH] || mdu_req_op[OP_MULHSU] || mdu_req_op[OP_MULHU];
            rneg_q <= rneg;
`ifdef LIEAT_MDU_DIV_EN
            div_q  <= op_div_any;
            rem_q  <= is_rem_op;
`endif
            if (fast) res_q <= fast_res;
        end else if ((state_q == ST_CALC) && !mdu_flush) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) res_q <= fin_res;
        end
    end

endmodule

// File: tb/tb_lieat_exu_mdu.sv
// Self-checking bench for lieat_exu_mdu (XLEN=32); honours LIEAT_MDU_DIV_EN
// in its reference model so it matches whichever build is compiled.
module tb_lieat_exu_mdu;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdu_req_valid = 1'b0;
    logic        mdu_req_ready;
    logic [31:0] mdu_req_op1 = '0;
    logic [31:0] mdu_req_op2 = '0;
    logic [7:0]  mdu_req_op = '0;
    logic        mdu_flush = 1'b0;
    logic        mdu_rsp_valid;
    logic        mdu_rsp_ready = 1'b0;
    logic [31:0] mdu_rsp_res;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lieat_exu_mdu #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mdu_req_valid (mdu_req_valid),
        .mdu_req_ready (mdu_req_ready),
        .mdu_req_op1   (mdu_req_op1),
        .mdu_req_op2   (mdu_req_op2),
        .mdu_req_op    (mdu_req_op),
        .mdu_flush     (mdu_flush),
        .mdu_rsp_valid (mdu_rsp_valid),
        .mdu_rsp_ready (mdu_rsp_ready),
        .mdu_rsp_res   (mdu_rsp_res)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        if ($countones(op) != 1) return '0;
`ifndef LIEAT_MDU_DIV_EN
        if (op[7:4] != 4'b0) return '0;
`endif
        if (op[0]) begin p = ua * ub; return p[31:0]; end
        if (op[1]) begin p = sa * sb; return p[63:32]; end
        if (op[2]) begin p = sa * longint'(ub); return p[63:32]; end
        if (op[3]) begin p = ua * ub; return p[63:32]; end
        if (op[4]) begin
            if (b == 0) return '1;
            if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
            p = sa / sb; return p[31:0];
        end
        if (op[5]) begin
            if (b == 0) return '1;
            p = ua / ub; return p[31:0];
        end
        if (op[6]) begin
            if (b == 0) return a;
            if (a == MIN32 && b == 32'hFFFF_FFFF) return '0;
            p = sa % sb; return p[31:0];
        end
        if (b == 0) return a;
        p = ua % ub;
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [7:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if ($countones(op) != 1) return 1;
`ifdef LIEAT_MDU_DIV_EN
        if (op[7:4] != 4'b0) begin
            if (b == 0) return 1;
            if ((op[4] || op[6]) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
        end
`else
        if (op[7:4] != 4'b0) return 1;
`endif
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN32;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!mdu_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mdu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%0b required 1", mdu_req_ready);
        end
        mdu_req_valid = 1'b1;
        mdu_req_op    = op;
        mdu_req_op1   = a;
        mdu_req_op2   = b;
    endtask

    task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int n;
        mdu_rsp_ready = 1'b1;
        issue(op, a, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) mdu_req_valid = 1'b0;
        end while (!mdu_rsp_valid && n < 100);
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s_lat: latency=%0d required %0d", name, n, exp_lat);
        end
        checks++;
        if (mdu_rsp_res !== exp) begin
            errors++;
            $display("FAIL %s_res: res=%h required %h (op=%h a=%h b=%h)", name, mdu_rsp_res, exp, op, a, b);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (mdu_rsp_valid !== 1'b0 || mdu_rsp_res !== 32'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%0b res=%h required 0/0", mdu_rsp_valid, mdu_rsp_res);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mdu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%0b required 1", mdu_req_ready);
        end
    endtask

    task automatic test_directed();
        run_op("mul_neg", 8'h01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_max", 8'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
`ifdef LIEAT_MDU_DIV_EN
        run_op("div_neg", 8'h10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_neg", 8'h40, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_zero", 8'h20, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_zero", 8'h80, 32'd100, 32'd0, 32'd100, 1);
        run_op("div_ovf", 8'h10, MIN32, 32'hFFFF_FFFF, MIN32, 1);
        run_op("rem_ovf", 8'h40, MIN32, 32'hFFFF_FFFF, 32'd0, 1);
`else
        run_op("div_off", 8'h10, 32'hFFFF_FFF9, 32'd2, 32'd0, 1);
        run_op("remu_off", 8'h80, 32'd100, 32'd0, 32'd0, 1);
`endif
        run_op("mulh_small", 8'h02, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 33);
        run_op("illegal_zero", 8'h00, 32'd3, 32'd4, 32'd0, 1);
        run_op("illegal_multi", 8'h03, 32'd3, 32'd4, 32'd0, 1);
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] a, b;
        int          r;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       op = 8'd1 << r;
            else if (r == 8) op = 8'($urandom());
            else             op = 8'h00;
            a = pick();
            b = pick();
            run_op("random", op, a, b, ref_res(op, a, b), ref_lat(op, a, b));
        end
    endtask

    task automatic test_flush();
        int n, highs;
        // flush in the middle of a multiply
        mdu_rsp_ready = 1'b1;
        issue(8'h01, 32'd123, 32'd456);
        for (n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) mdu_req_valid = 1'b0;
        end
        mdu_flush = 1'b1;
        @(negedge clk);
        mdu_flush = 1'b0;
        #1;
        checks++;
        if (mdu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_calc_ready: req_ready=%0b required 1", mdu_req_ready);
        end
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu_rsp_valid) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL flush_calc_drop: valid high %0d cycles required 0", highs);
        end
        // flush concurrent with a request: request must not be taken
        @(negedge clk);
        mdu_flush = 1'b1;
        mdu_req_valid = 1'b1;
        mdu_req_op = 8'h01;
        mdu_req_op1 = 32'd9;
        mdu_req_op2 = 32'd9;
        #1;
        checks++;
        if (mdu_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_ready: req_ready=%0b required 0", mdu_req_ready);
        end
        @(negedge clk);
        mdu_flush = 1'b0;
        mdu_req_valid = 1'b0;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            if (mdu_rsp_valid) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL flush_req_drop: valid high %0d cycles required 0", highs);
        end
        // flush while holding a result
        mdu_rsp_ready = 1'b0;
        issue(8'h01, 32'd5, 32'd6);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) mdu_req_valid = 1'b0;
        end while (!mdu_rsp_valid && n < 100);
        mdu_flush = 1'b1;
        @(negedge clk);
        mdu_flush = 1'b0;
        checks++;
        if (mdu_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: valid=%0b required 0", mdu_rsp_valid);
        end
    endtask

    task automatic test_stall();
        int n, bad;
        logic [31:0] exp;
        exp = ref_res(8'h04, 32'hFFFF_FF00, 32'h1234_5678);
        mdu_rsp_ready = 1'b0;
        issue(8'h04, 32'hFFFF_FF00, 32'h1234_5678);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) mdu_req_valid = 1'b0;
        end while (!mdu_rsp_valid && n < 100);
        checks++;
        if (n != 33 || mdu_rsp_res !== exp) begin
            errors++;
            $display("FAIL stall_first: lat=%0d res=%h required 33 %h", n, mdu_rsp_res, exp);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (mdu_rsp_valid !== 1'b1 || mdu_rsp_res !== exp || mdu_req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: %0d unstable cycles required 0 (res=%h want %h)", bad, mdu_rsp_res, exp);
        end
        mdu_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (mdu_rsp_valid !== 1'b0 || mdu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%0b ready=%0b required 0/1", mdu_rsp_valid, mdu_req_ready);
        end
        checks++;
        if (mdu_rsp_res !== exp) begin
            errors++;
            $display("FAIL stall_keep: res=%h required %h", mdu_rsp_res, exp);
        end
    endtask

    task automatic test_reset_mid();
        int highs;
        logic [7:0] op;
`ifdef LIEAT_MDU_DIV_EN
        op = 8'h10;
`else
        op = 8'h01;
`endif
        mdu_rsp_ready = 1'b1;
        issue(op, 32'hFFFF_FFF9, 32'd2);
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) mdu_req_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mdu_rsp_valid !== 1'b0 || mdu_rsp_res !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_out: valid=%0b res=%h required 0/0", mdu_rsp_valid, mdu_rsp_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mdu_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: req_ready=%0b required 1", mdu_req_ready);
        end
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (mdu_rsp_valid) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL reset_mid_drop: valid high %0d cycles required 0", highs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a = $urandom();
            b = $urandom();
            run_op("b2b", 8'h01, a, b, ref_res(8'h01, a, b), 33);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lieat_exu_mdu.md
LIEAT_EXU_MDU -- requirements
Module: lieat_exu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mdu_req_valid  input  1  request present.
REQ-005 SHALL have port mdu_req_ready  output  1  request accepted when valid&ready.
REQ-006 SHALL have ports mdu_req_op1, mdu_req_op2  input  XLEN  rs1/rs2 operands.
REQ-007 SHALL have port mdu_req_op  input  8  one-hot {remu,rem,divu,div,mulhu,mulhsu,mulh,mul}, bit0=mul.
REQ-008 SHALL have port mdu_flush  input  1  kill in-flight operation.
REQ-009 SHALL have port mdu_rsp_valid  output  1  result present.
REQ-010 SHALL have port mdu_rsp_ready  input  1  consumer takes result when valid&ready.
REQ-011 SHALL have port mdu_rsp_res  output  XLEN  result.

Function
REQ-012 SHALL implement FSM IDLE, CALC, DONE; mdu_req_ready = (state==IDLE) & ~mdu_flush.
REQ-013 SHALL on accept at cycle T latch operands/op, take sign-conditioned magnitudes per op, go CALC with iteration counter = XLEN.
REQ-014 SHALL multiply by radix-2 shift-add over a 2*XLEN accumulator, one bit per cycle, XLEN CALC cycles.
REQ-015 SHALL divide by radix-2 restoring division, one quotient bit per cycle, XLEN CALC cycles.
REQ-016 SHALL negate the final product/quotient/remainder per RISC-V M sign rules (remainder takes dividend sign).
REQ-017 SHALL enter DONE after last CALC cycle; mdu_rsp_valid first high at T+XLEN+1.
REQ-018 SHALL select product low half (mul) or high half (mulh/mulhsu/mulhu), quotient (div/divu), remainder (rem/remu).
REQ-019 SHALL fast-path divide by zero: IDLE->DONE, valid at T+1, quotient all-ones, remainder = op1.
REQ-020 SHALL fast-path signed overflow (op1=MIN, op2=-1): valid at T+1, quotient MIN, remainder 0.
REQ-021 SHALL fast-path illegal op (zero or >1 bits set): valid at T+1, result 0.
REQ-022 SHALL hold mdu_rsp_valid and mdu_rsp_res stable in DONE until mdu_rsp_ready; then go IDLE; no same-cycle accept.
REQ-023 SHALL on mdu_flush in any state go IDLE next cycle, drop the result, deassert mdu_rsp_valid next cycle.
REQ-024 SHALL give flush priority over simultaneous req_valid and rsp_ready; no request accepted that cycle.
REQ-025 SHALL keep mdu_rsp_res at its last value outside DONE.

Reset
REQ-026 SHALL on rst_n low asynchronously force state IDLE, counter 0, accumulators 0, mdu_rsp_valid 0, mdu_rsp_res 0.
REQ-027 SHALL abandon any operation on reset mid-operation, with no response after release.
REQ-028 SHALL have mdu_req_ready 1 first cycle after release (flush low).

Configuration
REQ-029 SHALL honour macro LIEAT_MDU_DIV_EN.
REQ-030 SHALL with LIEAT_MDU_DIV_EN defined implement all eight ops as above.
REQ-031 SHALL without it omit divider logic; div/divu/rem/remu are illegal ops (REQ-021); multiply timing unchanged.

Structure
REQ-032 SHALL place FSM state encodings, op one-hot bit indices and XLEN default in the shared defines file.
REQ-033 SHALL use one sub-module lieat_mdu_signfix (conditional two's-complement negate, XLEN-parametrised) for operand and result sign handling.
REQ-034 SHALL be single clock domain, no latches, all flops on clk with async rst_n.

Verification (XLEN=32)
REQ-035 SHALL test: mul op1=7 op2=0xFFFFFFFD accepted T -> rsp_valid at T+33, res 0xFFFFFFEB; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 SHALL test: div 0xFFFFFFF9/2 -> 0xFFFFFFFD at T+33; rem same operands -> 0xFFFFFFFF.
REQ-037 SHALL test: divu 100/0 -> 0xFFFFFFFF at T+1; remu 100/0 -> 100; div 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1, rem -> 0.
REQ-038 SHALL test: flush at T+10 of a mul -> rsp_valid never high, req_ready high at T+11; flush with req_valid same cycle -> not accepted.
REQ-039 SHALL test: rsp_ready low 5 cycles in DONE -> valid and res stable; rsp_ready high -> IDLE next cycle, ready high.
REQ-040 SHALL test: rst_n low at T+5 of a div -> outputs zero immediately; after release no response; build without LIEAT_MDU_DIV_EN -> div returns 0 at T+1.
